// File: rtl/rc4_key_search_ctrl.sv
// rtl/rc4_key_search_ctrl.sv - key-range sequencer for one RC4 init/shuffle/decrypt core
module rc4_key_search_ctrl #(
    parameter logic [23:0] KEY_START = 24'h000000,
    parameter logic [23:0] KEY_END   = 24'h3FFFFF,
    parameter logic [23:0] KEY_STEP  = 24'd1
) (
    input  logic        CLOCK_50,
    input  logic        reset_n,
    input  logic        start,
    input  logic        stop,
    input  logic        init_done,
    input  logic        shuffle_done,
    input  logic        decrypt_done,
    input  logic        decrypt_pass,
    input  logic [7:0]  init_addr,
    input  logic [7:0]  init_data,
    input  logic        init_we,
    input  logic [7:0]  shuf_addr,
    input  logic [7:0]  shuf_data,
    input  logic        shuf_we,
    input  logic [7:0]  dec_addr,
    input  logic [7:0]  dec_data,
    input  logic        dec_we,
    output logic [7:0]  s_addr,
    output logic [7:0]  s_data,
    output logic        s_wren,
    output logic        init_rst,
    output logic        shuffle_rst,
    output logic        decrypt_rst,
    output logic [23:0] secret_key,
    output logic        busy,
    output logic        found,
    output logic        exhausted,
    output logic [23:0] found_key,
    output logic [23:0] keys_tried
);

    typedef enum logic [2:0] {
        IDLE, INIT_RUN, SHUF_RUN, DEC_RUN, NEXT_KEY, FOUND, EXHAUSTED, ABORTED
    } state_t;

    state_t      state;
    state_t      state_nx;
    logic [24:0] key_sum;
    logic        key_last;
    logic        idle_like;

    // 25-bit sum so a wrap past 24'hFFFFFF is seen as the end of the range
    assign key_sum   = {1'b0, secret_key} + {1'b0, KEY_STEP};
    assign key_last  = key_sum[24] || (key_sum[23:0] > KEY_END);
    assign idle_like = (state == IDLE) || (state == FOUND) ||
                       (state == EXHAUSTED) || (state == ABORTED);

    always_comb begin
        state_nx = state;
        case (state)
            INIT_RUN: begin
                if (stop)           state_nx = ABORTED;
                else if (init_done) state_nx = SHUF_RUN;
            end
            SHUF_RUN: begin
                if (stop)              state_nx = ABORTED;
                else if (shuffle_done) state_nx = DEC_RUN;
            end
            DEC_RUN: begin
                if (stop)              state_nx = ABORTED;
                else if (decrypt_done) state_nx = decrypt_pass ? FOUND : NEXT_KEY;
            end
            NEXT_KEY: begin
                if (stop)          state_nx = ABORTED;
                else if (key_last) state_nx = EXHAUSTED;
                else               state_nx = INIT_RUN;
            end
            default: begin
                if (start) state_nx = INIT_RUN;
            end
        endcase
    end

    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            init_rst    <= 1'b1;
            shuffle_rst <= 1'b1;
            decrypt_rst <= 1'b1;
            secret_key  <= KEY_START;
            busy        <= 1'b0;
            found       <= 1'b0;
            exhausted   <= 1'b0;
            found_key   <= 24'h000000;
            keys_tried  <= 24'h000000;
        end else begin
            state       <= state_nx;
            init_rst    <= (state_nx != INIT_RUN);
            shuffle_rst <= (state_nx != SHUF_RUN);
            decrypt_rst <= (state_nx != DEC_RUN);
            busy        <= (state_nx == INIT_RUN) || (state_nx == SHUF_RUN) ||
                           (state_nx == DEC_RUN)  || (state_nx == NEXT_KEY);

            if (idle_like && start) begin
                secret_key <= KEY_START;
                keys_tried <= 24'h000000;
                found      <= 1'b0;
                exhausted  <= 1'b0;
                found_key  <= 24'h000000;
            end

            if (state == DEC_RUN && (state_nx == FOUND || state_nx == NEXT_KEY)) begin
                if (keys_tried != 24'hFFFFFF) keys_tried <= keys_tried + 24'd1;
                if (state_nx == FOUND) begin
                    found     <= 1'b1;
                    found_key <= secret_key;
                end
            end

            if (state == NEXT_KEY) begin
                if (state_nx == EXHAUSTED) exhausted  <= 1'b1;
                if (state_nx == INIT_RUN)  secret_key <= key_sum[23:0];
            end
        end
    end

    // S-memory goes to whichever engine owns the current state
    always_comb begin
        s_addr = 8'h00;
        s_data = 8'h00;
        s_wren = 1'b0;
        case (state)
            INIT_RUN: begin
                s_addr = init_addr;
                s_data = init_data;
                s_wren = init_we;
            end
            SHUF_RUN: begin
                s_addr = shuf_addr;
                s_data = shuf_data;
                s_wren = shuf_we;
            end
            DEC_RUN: begin
                s_addr = dec_addr;
                s_data = dec_data;
                s_wren = dec_we;
            end
            default: ;
        endcase
    end

endmodule
